seq_slice_adder: RTL and testbench
==================================

Name: seq_slice_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the combinational 8-bit Adder.
- Computes WIDTH-bit a±b with carry-in, one SLICE-bit slice per clock, through a registered carry chain.
- Adds a valid/ready input handshake, a valid/ack output handshake, a subtract mode and a signed-overflow flag.
- Sits between operand registers and the result bus, where a full-width ripple path does not meet timing.

Parameters:
- WIDTH, 8, operand and result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH must be an integer multiple of SLICE; otherwise elaboration fails (generate-time $error).
- N (localparam), WIDTH/SLICE, number of slice cycles.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  synchronous reset, active-high.
- iValid  input  1  operand set present.
- oReady  output  1  block can accept an operand set.
- iData_a  input  WIDTH  operand a.
- iData_b  input  WIDTH  operand b.
- iC  input  1  carry-in (add mode) or borrow-in (subtract mode).
- iSub  input  1  0 = a+b+iC; 1 = a-b-iC.
- oValid  output  1  result valid; held until acknowledged.
- iAck  input  1  consumer takes the result.
- oData  output  WIDTH  result.
- oData_C  output  1  raw carry-out of the MSB slice (in subtract mode 1 = no borrow).
- oOvf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: state IDLE; oReady=1; oValid=0; oData=0; oData_C=0; oOvf=0; slice counter and carry register cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE: oReady=1. On iValid & oReady at an edge, register a, b' and cin, and go to CALC with slice index 0.
  - Add mode: b' = b, cin = iC.
  - Subtract mode: b' = ~b, cin = ~iC.
- CALC: oReady=0.
  - Each edge adds slice i of a and b' plus the carry register into a SLICE+1-bit sum.
  - The low SLICE bits are written to result bits [i*SLICE +: SLICE]; the top bit becomes the carry register; i increments.
  - On the last slice (i = N-1), record the carry into the MSB (from bit WIDTH-1 of a + b' + internal carry) for oOvf, then go to DONE.
- DONE: oValid=1; oData, oData_C and oOvf are stable.
  - On iAck, go to IDLE; oValid drops the next cycle.
  - oReady stays 0 in DONE, so there is no accept in the same cycle as iAck.
  - Outputs keep their last value in IDLE until the next result overwrites them.
- Latency: acceptance edge k, slice i written at edge k+1+i, oValid high after edge k+N.
- Throughput: one operation per N+2 cycles at most.
- Held inputs: iValid held high in CALC or DONE is ignored. Operands are sampled only at the acceptance edge, so later changes on iData_a, iData_b, iC or iSub have no effect.
- iAck outside DONE is ignored.
- SLICE = WIDTH (N=1): one CALC cycle; behaviour is otherwise identical.
- Reset mid-operation (CALC or DONE): abort, all outputs return to reset values at that edge, oReady=1 the following cycle. No partial result is ever flagged valid.
- Arithmetic is modulo 2^WIDTH; oData_C is the carry out of bit WIDTH-1.

Test Plan (WIDTH=8, SLICE=4 unless noted):
- Add, carry-in: a=0x01, b=0x01, iC=1, iSub=0 -> oValid 2 cycles after acceptance, oData=0x03, C=0, Ovf=0. Cases with iC=0:
  - a=0x78, b=0x78 -> oData=0xF0, C=0, Ovf=1.
  - a=0x41, b=0xC1, iC=1 -> oData=0x03, C=1, Ovf=0.
  - a=0xFF, b=0xFF, iC=1 -> oData=0xFF, C=1, Ovf=0.
- Subtract:
  - a=0x05, b=0x07, iC=0, iSub=1 -> oData=0xFE, C=0 (borrow), Ovf=0.
  - a=0x80, b=0x01, iC=0 -> oData=0x7F, C=1, Ovf=1.
- Handshake:
  - Hold iValid=1 and change operands during CALC -> result matches the operands sampled at acceptance.
  - Hold iAck=0 for 5 cycles -> oValid and oData stay stable. Pulse iAck -> oValid=0 and oReady=1 on the next cycle.
- Reset mid-CALC: assert iRst at the first slice edge -> oValid never rises, outputs=0, oReady=1 the next cycle, and a fresh 0x01+0x01+1 then returns 0x03.
- Parameter sweep, WIDTH=16 with SLICE=16, 8 and 4:
  - 0xFFFF+0x0001+0 -> oData=0x0000, C=1, Ovf=0, with latency 1, 2 and 4 cycles respectively.
  - 1000 random operand and mode sets checked against a behavioural model.

Source files
------------

// File: rtl/seq_slice_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. Each clock adds one SLICE-bit slice
// through a registered carry, so the longest combinational path is one slice
// wide. Operands come in through a valid/ready handshake. The result is held
// with valid until the consumer acknowledges it.
module seq_slice_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iAck,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOvf
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_slice_adder: WIDTH must be an integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_reg, state_next;

  // The stored b is already inverted in subtract mode. This makes the slice
  // engine a plain adder for both modes.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             carry_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [SLICE-1:0] a_slices [N];
  logic [SLICE-1:0] b_slices [N];
  logic [SLICE-1:0] a_cur;
  logic [SLICE-1:0] b_cur;
  logic [SLICE:0]   slice_sum;
  logic             msb_carry_in;
  logic             accept;
  logic             last_slice;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slices
      assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  // Select the operand slices addressed by the slice counter.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_cur = a_slices[i];
        b_cur = b_slices[i];
      end
    end
  end

  assign slice_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE{1'b0}}, carry_reg};
  // Carry into the slice's top bit: sum bit = a ^ b ^ cin, so cin = a ^ b ^ sum.
  assign msb_carry_in = a_cur[SLICE-1] ^ b_cur[SLICE-1] ^ slice_sum[SLICE-1];
  assign last_slice   = (idx_reg == LAST_IDX);
  assign accept       = (state_reg == IDLE) && iValid;

  // Merge the current slice sum into the result word in place.
  always_comb begin
    result_next = result_reg;
    for (int i = 0; i < N; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        result_next[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. DONE never accepts, so an ack and a new operand set
  // cannot share a cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (iValid)     state_next = CALC;
      CALC:    if (last_slice) state_next = DONE;
      DONE:    if (iAck)       state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and flag recording.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      c_out_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      idx_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= iData_a;
            b_reg     <= iSub ? ~iData_b : iData_b;
            carry_reg <= iC ^ iSub;
            idx_reg   <= '0;
          end
        end
        CALC: begin
          result_reg <= result_next;
          carry_reg  <= slice_sum[SLICE];
          idx_reg    <= idx_reg + IDX_W'(1);
          if (last_slice) begin
            c_out_reg <= slice_sum[SLICE];
            ovf_reg   <= msb_carry_in ^ slice_sum[SLICE];
          end
        end
        default: ;
      endcase
    end
  end

  assign oReady  = (state_reg == IDLE);
  assign oValid  = (state_reg == DONE);
  assign oData   = result_reg;
  assign oData_C = c_out_reg;
  assign oOvf    = ovf_reg;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Bench for seq_slice_adder. It runs one 8-bit/4-bit-slice instance and three
// 16-bit instances with slices of 16, 8 and 4 bits. The three 16-bit instances
// share their inputs. Results are compared with an arithmetic reference model.
module tb_seq_slice_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid8;
  logic       ack8;
  logic       cin8;
  logic       sub8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       ready8_o;
  logic       valid8_o;
  logic [7:0] data8_o;
  logic       c8_o;
  logic       ovf8_o;

  logic        valid16;
  logic        ack16;
  logic        cin16;
  logic        sub16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        ready16_o [3];
  logic        valid16_o [3];
  logic [15:0] data16_o  [3];
  logic        c16_o     [3];
  logic        ovf16_o   [3];

  int total = 0;
  int bad   = 0;

  seq_slice_adder #(.WIDTH(8), .SLICE(4)) dut8 (
    .iClk(clk), .iRst(rst), .iValid(valid8), .oReady(ready8_o),
    .iData_a(a8), .iData_b(b8), .iC(cin8), .iSub(sub8),
    .oValid(valid8_o), .iAck(ack8), .oData(data8_o), .oData_C(c8_o), .oOvf(ovf8_o)
  );

  seq_slice_adder #(.WIDTH(16), .SLICE(16)) dut16_s16 (
    .iClk(clk), .iRst(rst), .iValid(valid16), .oReady(ready16_o[0]),
    .iData_a(a16), .iData_b(b16), .iC(cin16), .iSub(sub16),
    .oValid(valid16_o[0]), .iAck(ack16), .oData(data16_o[0]), .oData_C(c16_o[0]), .oOvf(ovf16_o[0])
  );

  seq_slice_adder #(.WIDTH(16), .SLICE(8)) dut16_s8 (
    .iClk(clk), .iRst(rst), .iValid(valid16), .oReady(ready16_o[1]),
    .iData_a(a16), .iData_b(b16), .iC(cin16), .iSub(sub16),
    .oValid(valid16_o[1]), .iAck(ack16), .oData(data16_o[1]), .oData_C(c16_o[1]), .oOvf(ovf16_o[1])
  );

  seq_slice_adder #(.WIDTH(16), .SLICE(4)) dut16_s4 (
    .iClk(clk), .iRst(rst), .iValid(valid16), .oReady(ready16_o[2]),
    .iData_a(a16), .iData_b(b16), .iC(cin16), .iSub(sub16),
    .oValid(valid16_o[2]), .iAck(ack16), .oData(data16_o[2]), .oData_C(c16_o[2]), .oOvf(ovf16_o[2])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: modular arithmetic, an unsigned borrow test and a signed range test.
  function automatic void model(input int w, input int a, input int b, input bit c, input bit s,
                                output int d, output bit co, output bit ov);
    longint la, lb, lc, full, mask, half, sa, sb, r;
    la   = longint'(a);
    lb   = longint'(b);
    lc   = c ? 64'sd1 : 64'sd0;
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    full = s ? (la - lb - lc) : (la + lb + lc);
    d    = int'(full & mask);
    co   = s ? (la >= lb + lc) : (((full >>> w) & 64'sd1) != 0);
    sa   = (la >= half) ? la - 2 * half : la;
    sb   = (lb >= half) ? lb - 2 * half : lb;
    r    = s ? (sa - sb - lc) : (sa + sb + lc);
    ov   = (r > half - 1) || (r < -half);
  endfunction

  // One 8-bit transaction. With hold set, iValid stays high and the operands
  // are scrambled during CALC. The result is then held unacknowledged for five
  // cycles before the ack.
  task automatic op8(input int a, input int b, input bit c, input bit s, input bit hold);
    int  d;
    bit  co;
    bit  ov;
    int  lat;
    int  w;
    logic [7:0] held_data;
    model(8, a, b, c, s, d, co, ov);
    w = 0;
    while (!ready8_o && w < 20) begin
      step();
      w++;
    end
    check_val("ready8_before", 32'(ready8_o), 1);
    a8     = a[7:0];
    b8     = b[7:0];
    cin8   = c;
    sub8   = s;
    valid8 = 1'b1;
    step();
    if (!hold) valid8 = 1'b0;
    lat = 0;
    while (!valid8_o && lat < 20) begin
      if (hold) begin
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
        sub8 = 1'($urandom);
      end
      step();
      lat++;
    end
    valid8 = 1'b0;
    check_val("lat8", 32'(lat), 2);
    check_val("data8", 32'(data8_o), 32'(d[7:0]));
    check_val("carry8", 32'(c8_o), 32'(co));
    check_val("ovf8", 32'(ovf8_o), 32'(ov));
    $display("op8 a=%02h b=%02h c=%0d sub=%0d -> data=%02h C=%0d ovf=%0d lat=%0d (exp %02h %0d %0d)",
             a[7:0], b[7:0], c, s, data8_o, c8_o, ovf8_o, lat, d[7:0], co, ov);
    if (hold) begin
      held_data = data8_o;
      for (int i = 0; i < 5; i++) begin
        step();
        check_val("stall_valid8", 32'(valid8_o), 1);
        check_val("stall_data8", 32'(data8_o), 32'(held_data));
        check_val("stall_ready8", 32'(ready8_o), 0);
      end
    end
    ack8 = 1'b1;
    step();
    ack8 = 1'b0;
    check_val("ack_valid8", 32'(valid8_o), 0);
    check_val("ack_ready8", 32'(ready8_o), 1);
  endtask

  // One transaction presented to all three 16-bit instances at the same edge.
  task automatic op16(input int a, input int b, input bit c, input bit s);
    int  d;
    bit  co;
    bit  ov;
    int  cyc;
    int  lat [3];
    bit  seen [3];
    int  lat_exp [3];
    lat_exp = '{1, 2, 4};
    lat     = '{0, 0, 0};
    seen    = '{1'b0, 1'b0, 1'b0};
    model(16, a, b, c, s, d, co, ov);
    for (int k = 0; k < 3; k++) check_val("ready16_before", 32'(ready16_o[k]), 1);
    a16     = a[15:0];
    b16     = b[15:0];
    cin16   = c;
    sub16   = s;
    valid16 = 1'b1;
    step();
    valid16 = 1'b0;
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 20) begin
      step();
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && valid16_o[k]) begin
          seen[k] = 1'b1;
          lat[k]  = cyc;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("lat16_%0d", k), 32'(lat[k]), 32'(lat_exp[k]));
      check_val($sformatf("data16_%0d", k), 32'(data16_o[k]), 32'(d[15:0]));
      check_val($sformatf("carry16_%0d", k), 32'(c16_o[k]), 32'(co));
      check_val($sformatf("ovf16_%0d", k), 32'(ovf16_o[k]), 32'(ov));
    end
    $display("op16 a=%04h b=%04h c=%0d sub=%0d -> data=%04h/%04h/%04h C=%0d ovf=%0d (exp %04h %0d %0d)",
             a[15:0], b[15:0], c, s, data16_o[0], data16_o[1], data16_o[2],
             c16_o[2], ovf16_o[2], d[15:0], co, ov);
    ack16 = 1'b1;
    step();
    ack16 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("ack_valid16_%0d", k), 32'(valid16_o[k]), 0);
      check_val($sformatf("ack_ready16_%0d", k), 32'(ready16_o[k]), 1);
    end
  endtask

  initial begin
    int w;
    rst = 1'b1;
    valid8 = 1'b0; ack8 = 1'b0; cin8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    valid16 = 1'b0; ack16 = 1'b0; cin16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    step();
    step();
    check_val("rst_ready8", 32'(ready8_o), 1);
    check_val("rst_valid8", 32'(valid8_o), 0);
    check_val("rst_data8", 32'(data8_o), 0);
    check_val("rst_carry8", 32'(c8_o), 0);
    check_val("rst_ovf8", 32'(ovf8_o), 0);
    for (int k = 0; k < 3; k++) begin
      check_val("rst_ready16", 32'(ready16_o[k]), 1);
      check_val("rst_valid16", 32'(valid16_o[k]), 0);
      check_val("rst_data16", 32'(data16_o[k]), 0);
    end
    rst = 1'b0;
    step();

    // Directed add and subtract cases.
    op8(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
    op8(8'h78, 8'h78, 1'b0, 1'b0, 1'b0);
    op8(8'h41, 8'hC1, 1'b1, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    op8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    // iValid held high, operands scrambled during CALC, then a stalled ack.
    op8(8'h3C, 8'h5A, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 100; i++) begin
      op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
    end

    // Reset lands on the first slice edge: the aborted operation must never flag valid.
    w = 0;
    while (!ready8_o && w < 20) begin
      step();
      w++;
    end
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midrst_valid8", 32'(valid8_o), 0);
    check_val("midrst_data8", 32'(data8_o), 0);
    check_val("midrst_carry8", 32'(c8_o), 0);
    check_val("midrst_ovf8", 32'(ovf8_o), 0);
    check_val("midrst_ready8", 32'(ready8_o), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("midrst_novalid8", 32'(valid8_o), 0);
    end
    $display("mid-calc reset applied, ready=%0d valid=%0d", ready8_o, valid8_o);
    op8(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);

    // 16-bit sweep across slice widths.
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      op16(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
           1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
